// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the program loader.
//   in_data/in_valid/in_ready : framed byte stream, transfer on valid & ready
//   mem_we/mem_addr/mem_wdata : one-cycle word write strobe into instruction memory
// slave  : the loader side (consumes the stream, drives the memory write)
// master : the feeding side (drives the stream, observes the memory write)
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: fills instruction memory from a framed byte stream and holds the core
// until a frame loads with a matching checksum.
// Frame: length N (2 bytes, LE), 4*N payload bytes (LE words), XOR checksum byte.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   start          : one-cycle load request, honoured in idle/done/error only
//   bus            : stream input and memory write output (imem_loader_if.slave)
//   core_hold      : high while the core must not run
//   done / error   : outcome of the last load (levels)
//   word_count     : words written in the current or last load
module imem_loader #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            core_hold,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] word_count
);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StCsum, StDone, StError
  } state_e;

  state_e            state_q;
  logic [15:0]       len_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_buf_q;   // b2,b1,b0 of the word being assembled
  logic [7:0]        csum_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic        xfer;
  logic [15:0] len_in;
  logic        len_ok;
  logic        last_word;

  assign xfer   = bus.in_valid & in_ready_q;
  assign len_in = {bus.in_data, len_q[7:0]};
  assign len_ok = (len_in != 16'd0) && ({1'b0, len_in} <= 17'(DEPTH));
  // word_count doubles as the word index: it equals the index of the word being assembled.
  assign last_word = (32'(word_count) + 32'd1) == 32'(len_q);

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      byte_idx_q  <= '0;
      word_buf_q  <= '0;
      csum_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_hold   <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
      word_count  <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            state_q    <= StLenLo;
            in_ready_q <= 1'b1;
            byte_idx_q <= '0;
            word_count <= '0;
            csum_q     <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            core_hold  <= 1'b1;
          end
        end
        StLenLo: begin
          if (xfer) begin
            len_q[7:0] <= bus.in_data;
            state_q    <= StLenHi;
          end
        end
        StLenHi: begin
          if (xfer) begin
            len_q <= len_in;
            if (len_ok) begin
              state_q <= StData;
            end else begin
              state_q    <= StError;
              error      <= 1'b1;
              in_ready_q <= 1'b0;
            end
          end
        end
        StData: begin
          if (xfer) begin
            csum_q     <= csum_q ^ bus.in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            word_buf_q <= {bus.in_data, word_buf_q[23:8]};
            if (byte_idx_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_count[ADDR_W-1:0];
              mem_wdata_q <= {bus.in_data, word_buf_q};
              word_count  <= word_count + {{ADDR_W{1'b0}}, 1'b1};
              if (last_word) state_q <= StCsum;
            end
          end
        end
        StCsum: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            if (bus.in_data == csum_q) begin
              state_q   <= StDone;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state_q <= StError;
              error   <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors with fixed expectations, random frames
// against a frame-level reference model, and hand-written reset/max-load sequences.
module tb_imem_loader;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            core_hold;
  logic            done;
  logic            error;
  logic [ADDR_W:0] word_count;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .start      (start),
    .bus        (bus),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  // Every cycle mem_we is high counts as one write.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
  end

  typedef struct packed {
    logic [87:0] bytes;     // byte 0 in the most significant position
    logic [3:0]  nbytes;
    logic        gaps;
    logic [3:0]  mid;       // byte index before which a stray start is pulsed, 0 = none
    logic        exp_done;
    logic [1:0]  nwr;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int t = 0; t < 16; t++) begin
      // in_ready only changes on posedge, so its negedge value holds at the next edge.
      if (bus.in_ready === 1'b1) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        return;
      end
      @(negedge clk);
    end
    n_cmp++;
    n_fail++;
    $display("FAIL handshake_timeout: in_ready stayed 0, want 1 within 16 cycles");
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] f[$], input bit gaps, input int mid);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    check("in_ready_after_start", 32'(bus.in_ready), 32'd1);
    check("core_hold_after_start", 32'(core_hold), 32'd1);
    check("done_after_start", 32'(done), 32'd0);
    check("error_after_start", 32'(error), 32'd0);
    check("word_count_after_start", 32'(word_count), 32'd0);
    foreach (f[i]) begin
      if (mid > 0 && i == mid) pulse_start();
      send_byte(f[i], gaps);
    end
  endtask

  // Reference model: decode the whole frame by its rules.
  task automatic model(input logic [7:0] f[$], output logic [31:0] words[$],
                       output bit exp_done);
    int unsigned n;
    logic [7:0]  x;
    words.delete();
    exp_done = 1'b0;
    n = 32'(f[0]) + 32'(f[1]) * 256;
    if (n == 0 || n > DEPTH) return;
    x = 8'h00;
    for (int i = 0; i < int'(n); i++) begin
      logic [31:0] w;
      w = 32'(f[2+4*i]) + (32'(f[3+4*i]) << 8) + (32'(f[4+4*i]) << 16) +
          (32'(f[5+4*i]) << 24);
      words.push_back(w);
      for (int k = 0; k < 4; k++) x = x ^ f[2+4*i+k];
    end
    exp_done = (f[2+4*n] == x);
  endtask

  task automatic check_result(input logic [31:0] words[$], input bit exp_done);
    check("write_count", 32'(wr_data_q.size()), 32'(words.size()));
    foreach (words[i]) begin
      if (i < wr_data_q.size()) begin
        check($sformatf("wr_addr[%0d]", i), 32'(wr_addr_q[i]), 32'(i));
        check($sformatf("wr_data[%0d]", i), wr_data_q[i], words[i]);
      end
    end
    check("done", 32'(done), 32'(exp_done));
    check("error", 32'(error), 32'(!exp_done));
    check("core_hold", 32'(core_hold), 32'(!exp_done));
    check("in_ready_end", 32'(bus.in_ready), 32'd0);
    check("word_count", 32'(word_count), 32'(words.size()));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_hold"}, 32'(core_hold), 32'd1);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [7:0]  f[$];
    logic [31:0] words[$];
    bit          exp_done;
    int unsigned n;
    logic [7:0]  x;

    vecs[0] = '{bytes: 88'h0200_1300_5000_9300_1000_C0, nbytes: 4'd11, gaps: 1'b0, mid: 4'd0,
                exp_done: 1'b1, nwr: 2'd2, w0: 32'h0050_0013, w1: 32'h0010_0093};
    vecs[1] = '{bytes: 88'h0200_1300_5000_9300_1000_C1, nbytes: 4'd11, gaps: 1'b0, mid: 4'd0,
                exp_done: 1'b0, nwr: 2'd2, w0: 32'h0050_0013, w1: 32'h0010_0093};
    vecs[2] = '{bytes: 88'h0000_0000_0000_0000_0000_00, nbytes: 4'd2, gaps: 1'b0, mid: 4'd0,
                exp_done: 1'b0, nwr: 2'd0, w0: 32'h0, w1: 32'h0};
    vecs[3] = '{bytes: 88'h0104_0000_0000_0000_0000_00, nbytes: 4'd2, gaps: 1'b0, mid: 4'd0,
                exp_done: 1'b0, nwr: 2'd0, w0: 32'h0, w1: 32'h0};
    vecs[4] = '{bytes: 88'h0200_1300_5000_9300_1000_C0, nbytes: 4'd11, gaps: 1'b1, mid: 4'd6,
                exp_done: 1'b1, nwr: 2'd2, w0: 32'h0050_0013, w1: 32'h0010_0093};
    vecs[5] = '{bytes: 88'h0100_EFBE_ADDE_2200_0000_00, nbytes: 4'd7, gaps: 1'b1, mid: 4'd0,
                exp_done: 1'b1, nwr: 2'd1, w0: 32'hDEAD_BEEF, w1: 32'h0};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset release.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // Table vectors with fixed expectations.
    for (int v = 0; v < 6; v++) begin
      f.delete();
      for (int i = 0; i < int'(vecs[v].nbytes); i++) f.push_back(vecs[v].bytes[87-8*i -: 8]);
      drive_frame(f, vecs[v].gaps, int'(vecs[v].mid));
      words.delete();
      if (vecs[v].nwr > 0) words.push_back(vecs[v].w0);
      if (vecs[v].nwr > 1) words.push_back(vecs[v].w1);
      check_result(words, vecs[v].exp_done);
    end

    // Random legal-length frames, some with corrupted checksum.
    for (int r = 0; r < 10; r++) begin
      f.delete();
      n = $urandom_range(1, 6);
      f.push_back(8'(n));
      f.push_back(8'(n >> 8));
      x = 8'h00;
      for (int i = 0; i < int'(4 * n); i++) begin
        f.push_back(8'($urandom));
        x = x ^ f[f.size()-1];
      end
      if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
      f.push_back(x);
      drive_frame(f, $urandom_range(0, 1) == 1, 0);
      model(f, words, exp_done);
      check_result(words, exp_done);
    end

    // Random illegal lengths (0 or above DEPTH).
    for (int r = 0; r < 3; r++) begin
      f.delete();
      n = (r == 0) ? 0 : $urandom_range(DEPTH + 1, 65535);
      f.push_back(8'(n));
      f.push_back(8'(n >> 8));
      drive_frame(f, 1'b1, 0);
      model(f, words, exp_done);
      check_result(words, exp_done);
    end

    // Maximum load: every address written, word_count MSB set.
    f.delete();
    f.push_back(8'(DEPTH));
    f.push_back(8'(DEPTH >> 8));
    x = 8'h00;
    for (int i = 0; i < int'(4 * DEPTH); i++) begin
      f.push_back(8'($urandom));
      x = x ^ f[f.size()-1];
    end
    f.push_back(x);
    drive_frame(f, 1'b0, 0);
    model(f, words, exp_done);
    check_result(words, exp_done);
    check("max_word_count_msb", 32'(word_count[ADDR_W]), 32'd1);

    // Reset in the middle of a word, then a clean load.
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h50;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_reset_no_write", 32'(wr_data_q.size()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    f.delete();
    for (int i = 0; i < 11; i++) f.push_back(vecs[0].bytes[87-8*i -: 8]);
    drive_frame(f, 1'b0, 0);
    model(f, words, exp_done);
    check_result(words, exp_done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
